// File: rtl/alu_uart_ctrl_if.sv
// Bus bundle between the ALU/UART control block and its UART receiver,
// UART transmitter and ALU neighbours.
interface alu_uart_ctrl_if #(
  parameter int N    = 8,
  parameter int OP_W = 6
);
  logic [N-1:0]    rxdata;
  logic            rxdone;
  logic            txbusy;
  logic            txdone;
  logic [N-1:0]    result;
  logic [N-1:0]    busa;
  logic [N-1:0]    busb;
  logic [OP_W-1:0] opcode;
  logic [N-1:0]    txdata;
  logic            txstart;
  logic            busy;
  logic            ovrerr;

  // Controller side
  modport master (
    input  rxdata, rxdone, txbusy, txdone, result,
    output busa, busb, opcode, txdata, txstart, busy, ovrerr
  );

  // Peripheral side (UART + ALU)
  modport slave (
    output rxdata, rxdone, txbusy, txdone, result,
    input  busa, busb, opcode, txdata, txstart, busy, ovrerr
  );
endinterface

// File: rtl/alu_uart_ctrl.sv
// Collects an (A, B, opcode) byte frame from the UART receiver, drives the ALU,
// then returns the ALU result to the UART transmitter as a single byte.
module alu_uart_ctrl #(
  parameter int N    = 8,
  parameter int OP_W = 6
) (
  input logic             clk,
  input logic             rst_n,
  alu_uart_ctrl_if.master bus
);

  generate
    if (N < 6 || OP_W > N) begin : g_bad_width
      $error("alu_uart_ctrl: N must be >= 6 and OP_W must not exceed N");
    end
  endgenerate

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t          state_reg, state_next;
  logic [N-1:0]    busa_reg, busa_next;
  logic [N-1:0]    busb_reg, busb_next;
  logic [OP_W-1:0] opcode_reg, opcode_next;
  logic [N-1:0]    txdata_reg, txdata_next;
  logic            txstart_reg, txstart_next;
  logic            ovrerr_reg, ovrerr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= WAIT_A;
      busa_reg    <= '0;
      busb_reg    <= '0;
      opcode_reg  <= '0;
      txdata_reg  <= '0;
      txstart_reg <= 1'b0;
      ovrerr_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      busa_reg    <= busa_next;
      busb_reg    <= busb_next;
      opcode_reg  <= opcode_next;
      txdata_reg  <= txdata_next;
      txstart_reg <= txstart_next;
      ovrerr_reg  <= ovrerr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    busa_next    = busa_reg;
    busb_next    = busb_reg;
    opcode_next  = opcode_reg;
    txdata_next  = txdata_reg;
    txstart_next = 1'b0;
    ovrerr_next  = ovrerr_reg;

    case (state_reg)
      WAIT_A: begin
        if (bus.rxdone) begin
          busa_next  = bus.rxdata;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.rxdone) begin
          busb_next  = bus.rxdata;
          state_next = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (bus.rxdone) begin
          opcode_next = bus.rxdata[OP_W-1:0];
          state_next  = EXEC;
        end
      end
      EXEC: begin
        // Operands have been on the ALU for a full cycle; result is settled.
        txdata_next = bus.result;
        state_next  = SEND;
      end
      SEND: begin
        if (!bus.txbusy) begin
          txstart_next = 1'b1;
          state_next   = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (bus.txdone) begin
          state_next = WAIT_A;
        end
      end
      default: state_next = WAIT_A;
    endcase

    // A byte arriving while a frame is being processed has nowhere to go.
    if (bus.rxdone && (state_reg == EXEC || state_reg == SEND || state_reg == WAIT_TX)) begin
      ovrerr_next = 1'b1;
    end
  end

  assign bus.busa    = busa_reg;
  assign bus.busb    = busb_reg;
  assign bus.opcode  = opcode_reg;
  assign bus.txdata  = txdata_reg;
  assign bus.txstart = txstart_reg;
  assign bus.ovrerr  = ovrerr_reg;
  assign bus.busy    = (state_reg != WAIT_A);

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl: a small ALU model answers the operands,
// and each frame's timing, data and overrun behaviour is checked at negedges.
module tb_alu_uart_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_uart_ctrl_if #(.N(8), .OP_W(6)) bus ();

  alu_uart_ctrl #(.N(8), .OP_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: a handful of opcodes, everything else answers 0xFF.
  always_comb begin
    case (bus.opcode)
      6'h20:   bus.result = bus.busa + bus.busb;
      6'h22:   bus.result = bus.busa - bus.busb;
      6'h24:   bus.result = bus.busa & bus.busb;
      6'h25:   bus.result = bus.busa | bus.busb;
      6'h00:   bus.result = {bus.busa[6:0], 1'b0};
      6'h02:   bus.result = {1'b0, bus.busa[7:1]};
      6'h03:   bus.result = {bus.busa[7], bus.busa[7:1]};
      default: bus.result = 8'hFF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rxdata = b;
    bus.rxdone = 1'b1;
    @(negedge clk);
    bus.rxdone = 1'b0;
  endtask

  // ovr_mode: 0 = clean, 1 = extra byte during WAIT_TX, 2 = byte together with TxDone
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input logic [5:0] exp_op, input logic [7:0] exp_res,
                       input int hold, input int ovr_mode, input string name);
    bus.txbusy = 1'b0;
    send_byte(a);
    check({name, "_busy_a"}, bus.busy, 1);
    check({name, "_busa"}, bus.busa, a);
    send_byte(b);
    check({name, "_busb"}, bus.busb, b);
    if (hold > 0) bus.txbusy = 1'b1;
    send_byte(op);
    check({name, "_opcode"}, bus.opcode, exp_op);
    check({name, "_txstart_exec"}, bus.txstart, 0);
    @(negedge clk);
    check({name, "_txdata"}, bus.txdata, exp_res);
    check({name, "_txstart_send"}, bus.txstart, 0);
    repeat (hold) begin
      @(negedge clk);
      check({name, "_txstart_held"}, bus.txstart, 0);
      check({name, "_txdata_held"}, bus.txdata, exp_res);
    end
    bus.txbusy = 1'b0;
    @(negedge clk);
    check({name, "_txstart_pulse"}, bus.txstart, 1);
    @(negedge clk);
    check({name, "_txstart_low"}, bus.txstart, 0);
    check({name, "_busy_wait_tx"}, bus.busy, 1);
    if (ovr_mode == 1) begin
      send_byte(8'h77);
      check({name, "_ovrerr"}, bus.ovrerr, 1);
      check({name, "_txdata_ovr"}, bus.txdata, exp_res);
      check({name, "_busy_ovr"}, bus.busy, 1);
    end
    @(negedge clk);
    bus.txdone = 1'b1;
    if (ovr_mode == 2) begin
      bus.rxdata = 8'h77;
      bus.rxdone = 1'b1;
    end
    @(negedge clk);
    bus.txdone = 1'b0;
    bus.rxdone = 1'b0;
    check({name, "_busy_done"}, bus.busy, 0);
    if (ovr_mode == 2) begin
      check({name, "_ovrerr_same"}, bus.ovrerr, 1);
      check({name, "_busa_kept"}, bus.busa, a);
    end
    $display("frame %s: A=%02h B=%02h OP=%02h -> TxData=%02h OvrErr=%0d",
             name, a, b, op, bus.txdata, bus.ovrerr);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.rxdata  = '0;
    bus.rxdone  = 1'b0;
    bus.txbusy  = 1'b0;
    bus.txdone  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busa", bus.busa, 0);
    check("rst_busb", bus.busb, 0);
    check("rst_opcode", bus.opcode, 0);
    check("rst_txdata", bus.txdata, 0);
    check("rst_txstart", bus.txstart, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ovrerr", bus.ovrerr, 0);
    rst_n = 1'b1;

    frame(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 0, 0, "add");
    frame(8'h03, 8'h05, 8'h22, 6'h22, 8'hFE, 0, 0, "sub");
    frame(8'h80, 8'h00, 8'h03, 6'h03, 8'hC0, 0, 0, "asr");
    check("ovrerr_clean", bus.ovrerr, 0);
    frame(8'h12, 8'h34, 8'h3F, 6'h3F, 8'hFF, 0, 0, "undef");
    frame(8'h12, 8'h34, 8'hE0, 6'h20, 8'h46, 0, 0, "opslice");
    frame(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 10, 0, "txbusy");
    frame(8'h09, 8'h04, 8'h24, 6'h24, 8'h00, 0, 1, "overrun");
    frame(8'h01, 8'h01, 8'h20, 6'h20, 8'h02, 0, 0, "post_ovr");
    check("ovrerr_sticky", bus.ovrerr, 1);

    // Asynchronous reset between the A and B bytes, away from any clock edge.
    send_byte(8'hAA);
    check("mid_busy", bus.busy, 1);
    check("mid_busa", bus.busa, 8'hAA);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busa", bus.busa, 0);
    check("arst_busb", bus.busb, 0);
    check("arst_opcode", bus.opcode, 0);
    check("arst_txdata", bus.txdata, 0);
    check("arst_txstart", bus.txstart, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_ovrerr", bus.ovrerr, 0);
    #1 rst_n = 1'b1;

    frame(8'h0F, 8'hF0, 8'h25, 6'h25, 8'hFF, 0, 0, "or");
    check("ovrerr_after_rst", bus.ovrerr, 0);
    frame(8'h02, 8'h03, 8'h20, 6'h20, 8'h05, 0, 2, "rx_tx_same");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
